// File: rtl/field_pkg.sv
// Shared types and default geometry for the piece/field merge datapath.
package field_pkg;

    localparam int DEF_FIELD_W = 10;
    localparam int DEF_FIELD_H = 20;
    localparam int DEF_BLK     = 4;
    localparam int FIELD_BITS  = DEF_FIELD_W * DEF_FIELD_H;
    localparam int BLK_BITS    = DEF_BLK * DEF_BLK;

    typedef logic [1:0] rot_t;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} fm_state_t;

endpackage

// File: rtl/field_merge_seq_if.sv
// Request/result bundle between game control (master) and field_merge_seq (slave).
// Handshake: start is a request taken only while busy=0 and done=0; a request at
// any other time is dropped. done is a one-cycle strobe marking field_out/collision valid.
interface field_merge_seq_if
    import field_pkg::*;
#(
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int FIELD_H = DEF_FIELD_H,
    parameter int BLK     = DEF_BLK,
    parameter int POS_W   = 5
);
    logic                       start;
    rot_t                       rotate;
    logic [POS_W-1:0]           pos_x;
    logic [POS_W-1:0]           pos_y;
    logic [BLK*BLK-1:0]         block_matrix;
    logic [FIELD_W*FIELD_H-1:0] field_bg;
    logic                       busy;
    logic                       done;
    logic                       collision;
    logic [FIELD_W*FIELD_H-1:0] field_out;

    modport master (
        output start, rotate, pos_x, pos_y, block_matrix, field_bg,
        input  busy, done, collision, field_out
    );

    modport slave (
        input  start, rotate, pos_x, pos_y, block_matrix, field_bg,
        output busy, done, collision, field_out
    );
endinterface

// File: rtl/block_rot_index.sv
// Maps a scan cell (bx, by) to the source mask bit for a clockwise quarter-turn rotation.
module block_rot_index
    import field_pkg::*;
#(
    parameter int  BLK = DEF_BLK,
    localparam int BW  = $clog2(BLK),
    localparam int CW  = $clog2(BLK * BLK)
) (
    input  rot_t          rotate,
    input  logic [BW-1:0] bx,
    input  logic [BW-1:0] by,
    output logic [CW-1:0] idx
);
    int x, y, i;

    always_comb begin
        x = int'(bx);
        y = int'(by);
        case (rotate)
            2'd0:    i = y * BLK + x;
            2'd1:    i = (BLK - 1 - x) * BLK + y;
            2'd2:    i = (BLK - 1 - y) * BLK + (BLK - 1 - x);
            default: i = x * BLK + (BLK - 1 - y);
        endcase
        idx = CW'(i);
    end
endmodule

// File: rtl/field_merge_seq.sv
// Sequential piece/field merge: scans the piece mask one cell per cycle and ORs it into a field snapshot.
// Optional FIELD_MERGE_EARLY_ABORT_EN: first collision ends the scan and restores the background.
module field_merge_seq
    import field_pkg::*;
#(
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int FIELD_H = DEF_FIELD_H,
    parameter int BLK     = DEF_BLK,
    parameter int POS_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    field_merge_seq_if.slave         bus,
    output fm_state_t                dbg_state
);
    localparam int NBITS = FIELD_W * FIELD_H;
    localparam int CELLS = BLK * BLK;
    localparam int BW    = $clog2(BLK);
    localparam int CW    = $clog2(CELLS);
    localparam int FW    = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(CELLS - 1);

    fm_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q;
    rot_t             rot_q;
    logic [POS_W-1:0] px_q, py_q;
    logic [CELLS-1:0] mask_q;
    logic [NBITS-1:0] field_q;
    logic             coll_q;
`ifdef FIELD_MERGE_EARLY_ABORT_EN
    logic [NBITS-1:0] bg_q;
`endif

    logic [BW-1:0] bx, by;
    logic [CW-1:0] src_idx;
    logic [FW-1:0] fidx;
    logic          in_range, hit, clash, busy, done;
    int            fx, fy;

    assign bx = BW'(int'(cnt_q) % BLK);
    assign by = BW'(int'(cnt_q) / BLK);

    block_rot_index #(.BLK(BLK)) u_rot (
        .rotate (rot_q),
        .bx     (bx),
        .by     (by),
        .idx    (src_idx)
    );

    // Coordinates are widened to int so pos + offset never wraps back into range.
    always_comb begin
        fx       = int'(px_q) + int'(bx);
        fy       = int'(py_q) + int'(by);
        in_range = (fx < FIELD_W) && (fy < FIELD_H);
        fidx     = in_range ? FW'(fy * FIELD_W + fx) : '0;
    end

    assign hit   = (state_q == SCAN) && mask_q[src_idx];
    assign clash = hit && (!in_range || field_q[fidx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: state_d = SCAN;
            SCAN: begin
                if (cnt_q == LAST) state_d = DONE;
`ifdef FIELD_MERGE_EARLY_ABORT_EN
                if (clash) state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == LOAD) || (state_q == SCAN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rot_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            mask_q  <= '0;
            field_q <= '0;
            coll_q  <= 1'b0;
`ifdef FIELD_MERGE_EARLY_ABORT_EN
            bg_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    rot_q   <= bus.rotate;
                    px_q    <= bus.pos_x;
                    py_q    <= bus.pos_y;
                    mask_q  <= bus.block_matrix;
                    field_q <= bus.field_bg;
                    coll_q  <= 1'b0;
`ifdef FIELD_MERGE_EARLY_ABORT_EN
                    bg_q    <= bus.field_bg;
`endif
                end
                LOAD: cnt_q <= '0;
                SCAN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (hit && in_range) field_q[fidx] <= 1'b1;
                    if (clash) coll_q <= 1'b1;
`ifdef FIELD_MERGE_EARLY_ABORT_EN
                    // Aborted merge leaves the untouched background as the result.
                    if (clash) field_q <= bg_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.collision = coll_q;
    assign bus.field_out = field_q;
    assign dbg_state     = state_q;
endmodule
